// File: rtl/clkgen_baud_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkgen_baud_pkg
// Brief    : Shared constants for the UART baud-timing controller.
// Revision : 1.0 - initial release
// ============================================================================
package clkgen_baud_pkg;

    localparam logic ADR_DIV  = 1'b0;
    localparam logic ADR_CTRL = 1'b1;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_RESTART = 1;
    localparam int CTRL_PEND    = 8;
    localparam int CTRL_SEEN    = 9;

    localparam int FRAC_WIDTH   = 4;

endpackage
`default_nettype wire

// File: rtl/clkgen_baud_divider.sv
`default_nettype none
// ============================================================================
// Module   : clkgen_baud_divider
// Brief    : Baud counter with double-buffered divider, tick and UART clock
//            generation. Fractional accumulator enabled by CLKGEN_BAUD_FRAC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module clkgen_baud_divider
    import clkgen_baud_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 26,
    parameter int OVS_LOG2    = 4
) (
    input  logic                  in_reset,
    input  logic                  out_clk,
    input  logic                  i_enable,
    input  logic                  i_restart,
    input  logic                  i_div_wr,
    input  logic [DIV_WIDTH-1:0]  i_div_data,
`ifdef CLKGEN_BAUD_FRAC_EN
    input  logic [FRAC_WIDTH-1:0] i_frac_data,
    output logic [FRAC_WIDTH-1:0] o_pend_frac,
`endif
    output logic [DIV_WIDTH-1:0]  o_pend_div,
    output logic                  o_pend,
    output logic                  o_tick_ovs,
    output logic                  o_tick_bit,
    output logic                  o_clk_uart
);

    localparam int                   c_CNT_W   = DIV_WIDTH + 1;
    localparam logic [DIV_WIDTH-1:0] c_DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

    logic [DIV_WIDTH-1:0] r_pend_div;
    logic [DIV_WIDTH-1:0] r_active_div;
    logic                 r_pend;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [OVS_LOG2-1:0]  r_ovs_cnt;
    logic                 r_tick_ovs;
    logic                 r_tick_bit;
    logic                 r_clk_uart;

    logic [DIV_WIDTH-1:0] w_new_div;
    logic [c_CNT_W-1:0]   w_limit;
    logic                 w_extend;
    logic                 w_term;
    logic                 w_reload;

    // A write landing on the boundary cycle bypasses straight into active.
    assign w_new_div = i_div_wr ? i_div_data : r_pend_div;
    assign w_limit   = {1'b0, r_active_div} + {{DIV_WIDTH{1'b0}}, w_extend};
    assign w_term    = i_enable & (r_cnt == w_limit);
    assign w_reload  = i_restart | ~i_enable | w_term;

    always_ff @(posedge out_clk or posedge in_reset) begin
        if (in_reset) begin
            r_pend_div   <= c_DEF_DIV;
            r_active_div <= c_DEF_DIV;
            r_pend       <= 1'b0;
            r_cnt        <= '0;
            r_ovs_cnt    <= '0;
            r_tick_ovs   <= 1'b0;
            r_tick_bit   <= 1'b0;
            r_clk_uart   <= 1'b0;
        end else begin
            r_pend_div <= w_new_div;
            if (w_reload) begin
                r_active_div <= w_new_div;
                r_pend       <= 1'b0;
            end else if (i_div_wr) begin
                r_pend       <= 1'b1;
            end

            if (w_reload) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (i_restart) begin
                r_ovs_cnt <= '0;
            end else if (w_term) begin
                r_ovs_cnt <= r_ovs_cnt + OVS_LOG2'(1);
            end

            r_tick_ovs <= w_term;
            r_tick_bit <= w_term & (&r_ovs_cnt);
            r_clk_uart <= r_clk_uart ^ w_term;
        end
    end

`ifdef CLKGEN_BAUD_FRAC_EN
    logic [FRAC_WIDTH-1:0] r_pend_frac;
    logic [FRAC_WIDTH-1:0] r_active_frac;
    logic [FRAC_WIDTH-1:0] r_acc;
    logic                  r_extend;
    logic [FRAC_WIDTH-1:0] w_new_frac;
    logic [FRAC_WIDTH:0]   w_acc_sum;

    assign w_new_frac = i_div_wr ? i_frac_data : r_pend_frac;
    assign w_acc_sum  = {1'b0, r_acc} + {1'b0, r_active_frac};
    assign w_extend   = r_extend;

    // Carry out of the accumulator stretches the following period by one cycle.
    always_ff @(posedge out_clk or posedge in_reset) begin
        if (in_reset) begin
            r_pend_frac   <= '0;
            r_active_frac <= '0;
            r_acc         <= '0;
            r_extend      <= 1'b0;
        end else begin
            r_pend_frac <= w_new_frac;
            if (w_reload) begin
                r_active_frac <= w_new_frac;
            end
            if (i_restart) begin
                r_acc    <= '0;
                r_extend <= 1'b0;
            end else if (w_term) begin
                r_acc    <= w_acc_sum[FRAC_WIDTH-1:0];
                r_extend <= w_acc_sum[FRAC_WIDTH];
            end
        end
    end

    assign o_pend_frac = r_pend_frac;
`else
    assign w_extend = 1'b0;
`endif

    assign o_pend_div = r_pend_div;
    assign o_pend     = r_pend;
    assign o_tick_ovs = r_tick_ovs;
    assign o_tick_bit = r_tick_bit;
    assign o_clk_uart = r_clk_uart;

endmodule
`default_nettype wire

// File: rtl/clkgen_baud_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clkgen_baud_ctrl
// Brief    : Wishbone-programmable UART baud-timing controller (DIV and
//            CTRL/STATUS registers). Define CLKGEN_BAUD_FRAC_EN for fractional DIV.
// Revision : 1.0 - initial release
// ============================================================================
module clkgen_baud_ctrl
    import clkgen_baud_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 26,
    parameter int OVS_LOG2    = 4
) (
    input  logic        in_reset,
    input  logic        out_clk,
    input  logic        s_wb_adr_i,
    input  logic [31:0] s_wb_dat_i,
    output logic [31:0] s_wb_dat_o,
    input  logic        s_wb_we_i,
    input  logic [3:0]  s_wb_sel_i,
    input  logic        s_wb_stb_i,
    output logic        s_wb_ack_o,
    output logic        out_tick_ovs,
    output logic        out_tick_bit,
    output logic        out_clk_uart
);

`ifdef CLKGEN_BAUD_FRAC_EN
    localparam int c_DIV_USED_W = DIV_WIDTH + FRAC_WIDTH;
`else
    localparam int c_DIV_USED_W = DIV_WIDTH;
`endif

    logic        r_ack;
    logic [31:0] r_dat_o;
    logic        r_en;
    logic        r_seen;

    logic [DIV_WIDTH-1:0] w_pend_div;
    logic                 w_pend;
    logic                 w_tick_ovs;
    logic                 w_wr;
    logic                 w_wr_div;
    logic                 w_wr_ctrl;
    logic                 w_restart;
    logic [31:0]          w_div_rd;
    logic [31:0]          w_ctrl_rd;
    logic [31:0]          w_div_merged;
    logic [31:0]          w_rd_data;
    logic                 w_unused;
`ifdef CLKGEN_BAUD_FRAC_EN
    logic [FRAC_WIDTH-1:0] w_pend_frac;
`endif

    // Accesses commit in the cycle ack is high.
    assign w_wr      = s_wb_stb_i & r_ack & s_wb_we_i;
    assign w_wr_div  = w_wr & (s_wb_adr_i == ADR_DIV);
    assign w_wr_ctrl = w_wr & (s_wb_adr_i == ADR_CTRL);
    assign w_restart = w_wr_ctrl & s_wb_sel_i[0] & s_wb_dat_i[CTRL_RESTART];

    always_comb begin
        w_div_rd = '0;
        w_div_rd[DIV_WIDTH-1:0] = w_pend_div;
`ifdef CLKGEN_BAUD_FRAC_EN
        w_div_rd[DIV_WIDTH +: FRAC_WIDTH] = w_pend_frac;
`endif
    end

    always_comb begin
        w_ctrl_rd = '0;
        w_ctrl_rd[CTRL_EN]   = r_en;
        w_ctrl_rd[CTRL_PEND] = w_pend;
        w_ctrl_rd[CTRL_SEEN] = r_seen;
    end

    always_comb begin
        w_div_merged = w_div_rd;
        for (int b = 0; b < 4; b++) begin
            if (s_wb_sel_i[b]) begin
                w_div_merged[8*b +: 8] = s_wb_dat_i[8*b +: 8];
            end
        end
    end

    assign w_rd_data = (s_wb_adr_i == ADR_CTRL) ? w_ctrl_rd : w_div_rd;
    assign w_unused  = &{1'b0, w_div_merged[31:c_DIV_USED_W]};

    always_ff @(posedge out_clk or posedge in_reset) begin
        if (in_reset) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
            r_en    <= 1'b1;
            r_seen  <= 1'b0;
        end else begin
            r_ack   <= s_wb_stb_i & ~r_ack;
            r_dat_o <= (s_wb_stb_i & ~r_ack) ? w_rd_data : '0;
            if (w_wr_ctrl && s_wb_sel_i[0]) begin
                r_en <= s_wb_dat_i[CTRL_EN];
            end
            if (w_tick_ovs) begin
                r_seen <= 1'b1;
            end else if (w_wr_ctrl && s_wb_sel_i[1] && s_wb_dat_i[CTRL_SEEN]) begin
                r_seen <= 1'b0;
            end
        end
    end

    clkgen_baud_divider #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV),
        .OVS_LOG2    (OVS_LOG2)
    ) u_divider (
        .in_reset    (in_reset),
        .out_clk     (out_clk),
        .i_enable    (r_en),
        .i_restart   (w_restart),
        .i_div_wr    (w_wr_div),
        .i_div_data  (w_div_merged[DIV_WIDTH-1:0]),
`ifdef CLKGEN_BAUD_FRAC_EN
        .i_frac_data (w_div_merged[DIV_WIDTH +: FRAC_WIDTH]),
        .o_pend_frac (w_pend_frac),
`endif
        .o_pend_div  (w_pend_div),
        .o_pend      (w_pend),
        .o_tick_ovs  (w_tick_ovs),
        .o_tick_bit  (out_tick_bit),
        .o_clk_uart  (out_clk_uart)
    );

    assign s_wb_ack_o   = r_ack;
    assign s_wb_dat_o   = r_dat_o;
    assign out_tick_ovs = w_tick_ovs;

endmodule
`default_nettype wire

// File: doc/clkgen_baud_ctrl.md
Name: clkgen_baud_ctrl

Overview:
- Programmable UART baud-timing controller running in the out_clk domain of the clock generator.
- Replaces the fixed divide-by-54 UART divider with a register-configurable divider on a 32-bit Wishbone slave port.
- Produces single-cycle oversample ticks, bit ticks and a square-wave UART clock.
- Divider changes take effect glitch-free at a period boundary, so UART cores never see a runt period.

Parameters:
- DIV_WIDTH, 16, integer divider width (period = DIV+1 out_clk cycles).
- DEFAULT_DIV, 26, reset value of DIV (50 MHz / 27 = 16 x 115.7 kbps).
- OVS_LOG2, 4, log2 of oversample ratio (bit tick every 2^OVS_LOG2 oversample ticks).

Ports:
- in_reset  input  1  async active-high reset
- out_clk  input  1  system clock (module clock)
- s_wb_adr_i  input  1  0=DIV, 1=CTRL/STATUS
- s_wb_dat_i  input  32  write data
- s_wb_dat_o  output  32  read data
- s_wb_we_i  input  1  write enable
- s_wb_sel_i  input  4  byte enables
- s_wb_stb_i  input  1  strobe
- s_wb_ack_o  output  1  acknowledge
- out_tick_ovs  output  1  oversample tick pulse
- out_tick_bit  output  1  bit tick pulse
- out_clk_uart  output  1  square wave, toggles on each oversample tick

Behaviour:
- Interface: reset in_reset, asynchronous, active-high; clock out_clk. All state is cleared asynchronously by in_reset.
- Reset values:
  - DIV=DEFAULT_DIV, pending DIV=DEFAULT_DIV, pend flag=0
  - enable=1
  - counters=0, ovs_cnt=0
  - s_wb_ack_o=0, s_wb_dat_o=0
  - out_tick_ovs=0, out_tick_bit=0, out_clk_uart=0
- Wishbone access:
  - ack = registered (stb & ~ack): asserts 1 cycle after stb, holds for one cycle, then drops for at least one cycle. Master holds stb until ack.
  - Write or read commits in the cycle ack is asserted.
  - Byte enables apply per byte.
  - s_wb_dat_o is registered and valid with ack; it is 0 when ack=0.
- DIV register (adr 0):
  - bits [DIV_WIDTH-1:0] = divider; other bits read 0.
  - A write loads the pending register and sets pend. The active DIV is updated from pending at the next terminal count, i.e. the cycle out_tick_ovs fires, and pend clears.
  - If enable=0, the update is immediate (next cycle).
  - Read returns the pending value.
- CTRL/STATUS register (adr 1):
  - bit0 enable, R/W.
  - bit1 restart, W1 pulse, reads 0: next cycle clears div counter and ovs_cnt and loads pending into active.
  - bit8 pend, RO.
  - bit9 tick-seen sticky, set by out_tick_ovs, cleared by writing 1 to bit9.
  - Simultaneous set and clear: set wins.
- Divider counter:
  - Counts 0..DIV. At DIV it wraps to 0 and out_tick_ovs=1 for that one cycle (registered output, valid the cycle after count==DIV).
  - DIV=0 gives a tick every cycle.
  - enable=0: counter holds at 0, no ticks, out_clk_uart holds its current level.
- ovs_cnt (OVS_LOG2 bits):
  - Increments on each oversample tick and wraps naturally.
  - out_tick_bit=1 in the same cycle as the out_tick_ovs whose ovs_cnt wraps to 0.
- out_clk_uart toggles on every out_tick_ovs.
- Restart and terminal count in the same cycle: restart wins; that tick is still emitted.
- Write to DIV in the same cycle as terminal count: the new value is loaded at this boundary.
- No combinational path from Wishbone inputs to tick outputs.

Optional Feature:
- Macro: CLKGEN_BAUD_FRAC_EN.
- Defined:
  - DIV bits [DIV_WIDTH+3:DIV_WIDTH] hold a 4-bit fraction F, R/W and double-buffered with the integer part.
  - A 4-bit accumulator adds F at each terminal count. On carry out, the next period is DIV+2 cycles instead of DIV+1.
  - Average period = DIV+1+F/16. The accumulator resets to 0 on reset and on restart.
- Undefined: fraction bits read 0, writes are ignored, no accumulator logic.

Decomposition:
- Package clkgen_baud_pkg holds:
  - register address constants ADR_DIV=0, ADR_CTRL=1
  - CTRL bit indices (EN=0, RESTART=1, PEND=8, SEEN=9)
  - FRAC_WIDTH=4
- One sub-module, clkgen_baud_divider: the counter, pending/active reload, fractional accumulator, and tick and square-wave generation.
- The top level holds the Wishbone register file.

Test Plan:
- Reset, then no access -> out_tick_ovs every 27 cycles; out_tick_bit every 432 cycles; out_clk_uart period 54 cycles.
- Write DIV=4 mid-period -> current 27-cycle period completes, then ticks every 5 cycles; pend reads 1 before the boundary and 0 after.
- Write DIV=0 -> tick every cycle; out_tick_bit every 16 cycles.
- CTRL enable=0 -> no ticks, out_clk_uart frozen. Write DIV=9 -> immediately active. Re-enable -> first tick 10 cycles after enable.
- Wishbone: stb held 4 cycles -> exactly one ack in cycle 2 and one re-ack in cycle 4. Write to DIV with sel=4'b0001, data 0xFFFF -> DIV low byte only = 0xFF, upper byte unchanged (0x00).
- With CLKGEN_BAUD_FRAC_EN: DIV=26, F=8 -> periods alternate 27/28 cycles, 16 ticks total 440 cycles. Assert in_reset mid-period -> all outputs 0 asynchronously.
